cla_sub_pipe_26bit: RTL and testbench

//   Two-stage pipelined carry-lookahead subtractor. It is the inverse arithmetic

---
 rtl/cla_sub_pipe_26bit_if.sv | 24 ++
 rtl/cla_sub_pipe_26bit.sv | 101 ++++++++++
 tb/tb_cla_sub_pipe_26bit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cla_sub_pipe_26bit_if.sv
// Operand/result handshake bundle for the pipelined CLA subtractor.
// The master side supplies operands and consumes results; the slave side is the subtractor.
interface cla_sub_pipe_26bit_if #(
  parameter int WIDTH = 26
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_minuend;
  logic [WIDTH-1:0] i_subtrahend;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_diff;
  logic             o_borrow;

  modport master (
    output i_valid, i_minuend, i_subtrahend, i_ready,
    input  o_ready, o_valid, o_diff, o_borrow
  );

  modport slave (
    input  i_valid, i_minuend, i_subtrahend, i_ready,
    output o_ready, o_valid, o_diff, o_borrow
  );
endinterface

// File: rtl/cla_sub_pipe_26bit.sv
// Two-stage pipelined carry-lookahead subtractor: diff = A + ~B + 1, borrow = ~carry_out.
// Stage 1 resolves the low LO_WIDTH bits and their carry; stage 2 resolves the rest.
module cla_sub_pipe_26bit #(
  parameter int WIDTH    = 26,
  parameter int LO_WIDTH = 13
) (
  input logic                 i_clk,
  input logic                 i_rst,
  cla_sub_pipe_26bit_if.slave bus
);
  localparam int HI_WIDTH = WIDTH - LO_WIDTH;

  // Handshake
  logic out_adv;
  logic s1_adv;
  logic in_fire;

  // Stage 1 registers
  logic                s1_valid;
  logic [LO_WIDTH-1:0] s1_diff_lo;
  logic                s1_carry;
  logic [HI_WIDTH-1:0] s1_a_hi;
  logic [HI_WIDTH-1:0] s1_bn_hi;

  // Output stage registers
  logic             out_valid;
  logic [WIDTH-1:0] out_diff;
  logic             out_borrow;

  // Combinational carry chains
  logic [WIDTH-1:0]    bn;
  logic [LO_WIDTH:0]   c_lo;
  logic [LO_WIDTH-1:0] diff_lo;
  logic [HI_WIDTH:0]   c_hi;
  logic [HI_WIDTH-1:0] diff_hi;

  assign out_adv     = ~out_valid | bus.i_ready;
  assign s1_adv      = ~s1_valid | out_adv;
  assign in_fire     = bus.i_valid & s1_adv;
  assign bus.o_ready = s1_adv;
  assign bn          = ~bus.i_subtrahend;

  // Low half: generate/propagate recurrence seeded with the +1 of two's complement.
  always_comb begin
    c_lo    = '0;
    diff_lo = '0;
    c_lo[0] = 1'b1;
    for (int i = 0; i < LO_WIDTH; i++) begin
      c_lo[i+1]  = (bus.i_minuend[i] & bn[i]) | ((bus.i_minuend[i] | bn[i]) & c_lo[i]);
      diff_lo[i] = bus.i_minuend[i] ^ bn[i] ^ c_lo[i];
    end
  end

  // High half continues from the registered split carry.
  always_comb begin
    c_hi    = '0;
    diff_hi = '0;
    c_hi[0] = s1_carry;
    for (int i = 0; i < HI_WIDTH; i++) begin
      c_hi[i+1]  = (s1_a_hi[i] & s1_bn_hi[i]) | ((s1_a_hi[i] | s1_bn_hi[i]) & c_hi[i]);
      diff_hi[i] = s1_a_hi[i] ^ s1_bn_hi[i] ^ c_hi[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the two stages shift cleanly in one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid   <= 1'b0;
      s1_diff_lo <= '0;
      s1_carry   <= 1'b0;
      s1_a_hi    <= '0;
      s1_bn_hi   <= '0;
      out_valid  <= 1'b0;
      out_diff   <= '0;
      out_borrow <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_fire;
      end
      if (in_fire) begin
        s1_diff_lo <= diff_lo;
        s1_carry   <= c_lo[LO_WIDTH];
        s1_a_hi    <= bus.i_minuend[WIDTH-1:LO_WIDTH];
        s1_bn_hi   <= bn[WIDTH-1:LO_WIDTH];
      end
      if (out_adv) begin
        out_valid <= s1_valid;
      end
      // Result registers load only with real data, so they hold while idle or stalled.
      if (s1_valid && out_adv) begin
        out_diff   <= {diff_hi, s1_diff_lo};
        out_borrow <= ~c_hi[HI_WIDTH];
      end
    end
  end

  assign bus.o_valid  = out_valid;
  assign bus.o_diff   = out_diff;
  assign bus.o_borrow = out_borrow;
endmodule

// File: tb/tb_cla_sub_pipe_26bit.sv
// Directed and randomised checks of the pipelined 26-bit subtractor against an (A-B) model.
module tb_cla_sub_pipe_26bit;
  logic i_clk;
  logic i_rst;

  cla_sub_pipe_26bit_if #(.WIDTH(26)) bus ();

  cla_sub_pipe_26bit dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests  = 0;
  int failed = 0;

  logic [26:0] sb_q[$];
  logic        prev_stall;
  logic [25:0] prev_diff;
  logic        prev_borrow;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One directed op through an idle pipeline with i_ready high; caller sits 1ns after a rising edge.
  task automatic run_op(input string tag, input logic [25:0] a, input logic [25:0] b,
                        input logic [25:0] exp_diff, input logic exp_borrow);
    bus.i_valid      = 1'b1;
    bus.i_minuend    = a;
    bus.i_subtrahend = b;
    bus.i_ready      = 1'b1;
    @(posedge i_clk); #1;
    bus.i_valid = 1'b0;
    check({tag, "_lat1_valid"}, bus.o_valid, 1'b0);
    @(posedge i_clk); #1;
    check({tag, "_valid"},  bus.o_valid,  1'b1);
    check({tag, "_diff"},   bus.o_diff,   exp_diff);
    check({tag, "_borrow"}, bus.o_borrow, exp_borrow);
    @(posedge i_clk); #1;
    check({tag, "_retired"}, bus.o_valid, 1'b0);
    check({tag, "_hold"},    bus.o_diff,  exp_diff);
  endtask

  // One scoreboarded cycle: drive, settle, check outputs and handshake, then advance a clock.
  task automatic step(input string tag, input logic v, input logic [25:0] a,
                      input logic [25:0] b, input logic rdy);
    logic [26:0] exp;
    bus.i_valid      = v;
    bus.i_minuend    = a;
    bus.i_subtrahend = b;
    bus.i_ready      = rdy;
    #1;
    if (prev_stall) begin
      check({tag, "_stall_valid"},  bus.o_valid,  1'b1);
      check({tag, "_stall_diff"},   bus.o_diff,   prev_diff);
      check({tag, "_stall_borrow"}, bus.o_borrow, prev_borrow);
    end
    check({tag, "_ready_rule"}, bus.o_ready, !(sb_q.size() == 2 && !rdy));
    if (bus.o_valid && rdy) begin
      if (sb_q.size() == 0) begin
        check({tag, "_spurious"}, bus.o_valid, 1'b0);
      end else begin
        exp = sb_q.pop_front();
        check({tag, "_result"}, {bus.o_borrow, bus.o_diff}, exp);
      end
    end
    prev_stall  = bus.o_valid & !rdy;
    prev_diff   = bus.o_diff;
    prev_borrow = bus.o_borrow;
    if (v && bus.o_ready) sb_q.push_back({1'b0, a} - {1'b0, b});
    @(posedge i_clk); #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) step(tag, 1'b0, '0, '0, 1'b1);
    check({tag, "_empty"}, sb_q.size(), 0);
  endtask

  initial begin
    prev_stall       = 1'b0;
    prev_diff        = '0;
    prev_borrow      = 1'b0;
    i_rst            = 1'b1;
    bus.i_valid      = 1'b0;
    bus.i_minuend    = '0;
    bus.i_subtrahend = '0;
    bus.i_ready      = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("rst_valid",  bus.o_valid,  1'b0);
    check("rst_diff",   bus.o_diff,   26'h0);
    check("rst_borrow", bus.o_borrow, 1'b0);
    check("rst_ready",  bus.o_ready,  1'b1);

    // Directed vectors
    run_op("t1_basic",      26'd5,       26'd3,       26'd2,       1'b0);
    run_op("t2_under",      26'd3,       26'd5,       26'h3FFFFFE, 1'b1);
    run_op("t2_zero_m1",    26'd0,       26'd1,       26'h3FFFFFF, 1'b1);
    run_op("t3_split",      26'h0002000, 26'h0000001, 26'h0001FFF, 1'b0);
    run_op("t3_equal_max",  26'h3FFFFFF, 26'h3FFFFFF, 26'h0,       1'b0);
    run_op("t3_top_chain",  26'h2000000, 26'h0000001, 26'h1FFFFFF, 1'b0);
    run_op("t3_split_neg",  26'h0001000, 26'h0002000, 26'h3FFF000, 1'b1);
    run_op("t3_split_m1",   26'h0002000, 26'h0002001, 26'h3FFFFFF, 1'b1);
    run_op("t3_mixed",      26'h1234567, 26'h0ABCDEF, 26'h0777778, 1'b0);

    // Back-to-back with no backpressure: no bubbles after the fill latency
    for (int cyc = 0; cyc < 102; cyc++) begin
      if (cyc >= 2) check("t4_no_bubble", bus.o_valid, 1'b1);
      if (cyc < 100) step("t4", 1'b1, 26'($urandom), 26'($urandom), 1'b1);
      else           step("t4", 1'b0, '0, '0, 1'b1);
    end
    drain("t4_drain");

    // Random valid and ready
    prev_stall = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      step("t5", ($urandom_range(0, 9) < 7), 26'($urandom), 26'($urandom),
           ($urandom_range(0, 9) < 7));
    end
    prev_stall = 1'b0;
    drain("t5_drain");

    // Reset with two ops in flight
    bus.i_ready      = 1'b0;
    bus.i_valid      = 1'b1;
    bus.i_minuend    = 26'd100;
    bus.i_subtrahend = 26'd1;
    @(posedge i_clk); #1;
    bus.i_minuend    = 26'd50;
    bus.i_subtrahend = 26'd60;
    @(posedge i_clk); #1;
    bus.i_valid = 1'b0;
    check("t6_full_ready", bus.o_ready, 1'b0);
    check("t6_pre_valid",  bus.o_valid, 1'b1);
    check("t6_pre_diff",   bus.o_diff,  26'd99);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst       = 1'b0;
    bus.i_ready = 1'b1;
    check("t6_valid",  bus.o_valid,  1'b0);
    check("t6_diff",   bus.o_diff,   26'h0);
    check("t6_borrow", bus.o_borrow, 1'b0);
    check("t6_ready",  bus.o_ready,  1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk); #1;
      check("t6_flushed", bus.o_valid, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
